// File: rtl/image_loader_if.sv
// ----------------------------------------------------------------------------
// image_loader_if
//
// Bundles the UART RX byte stream, the frame-buffer BRAM port A write
// signals and the loader status flags into one connection.
//
//   rx_data     [7:0]   received byte, qualified by rx_valid
//   rx_valid            one-cycle strobe per received byte
//   bram_we             BRAM port A write enable
//   bram_addr   [18:0]  BRAM port A address, linear pixel index y*W+x
//   bram_wdata  [7:0]   pixel byte, 00000RGB
//   busy                a frame is open (header seen, not yet finished)
//   done                sticky: last frame completed
//   error               sticky: last frame aborted by inter-byte timeout
//
// Modports:
//   master  UART side / system: drives the byte stream, observes the rest
//   slave   the loader: consumes the byte stream, drives BRAM and status
// ----------------------------------------------------------------------------
interface image_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        bram_we;
  logic [18:0] bram_addr;
  logic [7:0]  bram_wdata;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output rx_data,
    output rx_valid,
    input  bram_we,
    input  bram_addr,
    input  bram_wdata,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output bram_we,
    output bram_addr,
    output bram_wdata,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/image_loader.sv
// ----------------------------------------------------------------------------
// image_loader
//
// Takes a framed pixel stream from the UART receiver and writes it into the
// frame-buffer BRAM write port as RGB111 bytes. A frame is the header
// 0xAA 0x55 followed by exactly IMG_WIDTH*IMG_HEIGHT pixel bytes. Pixels are
// written at a linear address matching the display read mapping (y*W+x).
// If the sender stalls for too long while a frame is open, the frame is
// abandoned and the error flag is raised; BRAM contents are left as written.
//
// Parameters:
//   IMG_WIDTH       pixels per line
//   IMG_HEIGHT      lines per frame
//   TIMEOUT_CYCLES  idle cycles between bytes that abort an open frame
//
// Ports:
//   clk_25mhz  system pixel clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   bus        image_loader_if.slave: rx byte stream in, BRAM port A and
//              busy/done/error status out
//
// State table:
//   state  | meaning
//   IDLE   | no frame open, waiting for 0xAA
//   SYNC   | 0xAA seen, waiting for 0x55 (repeated 0xAA tolerated)
//   LOAD   | header complete, every byte is a pixel written to BRAM
// ----------------------------------------------------------------------------
module image_loader #(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input logic            clk_25mhz,
  input logic            reset_n,
  image_loader_if.slave  bus
);

  localparam int          PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam logic [18:0] LAST_PIX  = 19'(PIX_TOTAL - 1);

  localparam logic [7:0]  HDR_0 = 8'hAA;
  localparam logic [7:0]  HDR_1 = 8'h55;

  // idle_cnt only ever needs to hold up to TIMEOUT_CYCLES-2: the cycle that
  // would bring it to TIMEOUT_CYCLES-1 fires the timeout instead.
  localparam int                IDLE_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] TO_LAST = IDLE_W'(TIMEOUT_CYCLES - 2);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t            state;
  logic [18:0]       pix_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  logic              we_q;
  logic [18:0]       addr_q;
  logic [7:0]        wdata_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              frame_open;
  logic              timeout_hit;

  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign frame_open  = (state == S_SYNC) || (state == S_LOAD);
  assign timeout_hit = frame_open && !bus.rx_valid && (idle_cnt == TO_LAST);

  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pix_cnt  <= '0;
      idle_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;

      if (timeout_hit) begin
        state    <= S_IDLE;
        idle_cnt <= '0;
        busy_q   <= 1'b0;
        error_q  <= 1'b1;
        done_q   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            idle_cnt <= '0;
            if (bus.rx_valid && (bus.rx_data == HDR_0)) begin
              state  <= S_SYNC;
              busy_q <= 1'b1;
            end
          end

          S_SYNC: begin
            if (bus.rx_valid) begin
              idle_cnt <= '0;
              if (bus.rx_data == HDR_1) begin
                state   <= S_LOAD;
                pix_cnt <= '0;
                done_q  <= 1'b0;
                error_q <= 1'b0;
              end else if (bus.rx_data != HDR_0) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              idle_cnt <= idle_cnt + IDLE_ONE;
            end
          end

          S_LOAD: begin
            if (bus.rx_valid) begin
              idle_cnt <= '0;
              we_q     <= 1'b1;
              addr_q   <= pix_cnt;
              wdata_q  <= {5'b0, bus.rx_data[2:0]};
              // The final pixel closes the frame; pix_cnt is left at the
              // last index rather than wrapping and is reloaded by the next
              // header.
              if (pix_cnt == LAST_PIX) begin
                state   <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                error_q <= 1'b0;
              end else begin
                pix_cnt <= pix_cnt + 19'd1;
              end
            end else begin
              idle_cnt <= idle_cnt + IDLE_ONE;
            end
          end

          default: begin
            state    <= S_IDLE;
            idle_cnt <= '0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_image_loader.sv
`timescale 1ns/1ps
module tb_image_loader;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int PIX = W * H;
  localparam int TO  = 50;

  logic clk_25mhz;
  logic reset_n;

  image_loader_if bus();

  image_loader #(
    .IMG_WIDTH      (W),
    .IMG_HEIGHT     (H),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_25mhz (clk_25mhz),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge
  // and the task returns at the following falling edge. Consecutive calls
  // keep rx_valid high, giving back-to-back bytes.
  task automatic put(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(negedge clk_25mhz);
    bus.rx_valid = 1'b0;
  endtask

  task automatic put_px(input logic [7:0] d, input int a, input logic [7:0] ed);
    exp_q.push_back('{addr: 19'(a), data: ed});
    put(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  task automatic chk_status(input string tag, input logic b, input logic d, input logic e);
    chk({tag, " busy"},  32'(bus.busy),  32'(b));
    chk({tag, " done"},  32'(bus.done),  32'(d));
    chk({tag, " error"}, 32'(bus.error), 32'(e));
  endtask

  // Write monitor: every BRAM write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_25mhz);
      if (bus.bram_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected at %0t",
                   bus.bram_addr, bus.bram_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.bram_addr), 32'(e.addr));
          chk("wr_data", 32'(bus.bram_wdata), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset_n      = 1'b0;
    idle(3);

    // reset state
    chk("rst bram_we",    32'(bus.bram_we),    32'd0);
    chk("rst bram_addr",  32'(bus.bram_addr),  32'd0);
    chk("rst bram_wdata", 32'(bus.bram_wdata), 32'd0);
    chk_status("rst", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // full frame, pattern i%8, two idle cycles between bytes
    put(8'hAA);
    chk("frame busy after AA", 32'(bus.busy), 32'd1);
    put(8'h55);
    for (int i = 0; i < PIX; i++) begin
      put_px(8'(i % 8), i, 8'(i % 8));
      if (i == PIX - 2) chk_status("frame penult", 1'b1, 1'b0, 1'b0);
      if (i == PIX - 1) begin
        chk("frame last we", 32'(bus.bram_we), 32'd1);
        chk_status("frame last", 1'b0, 1'b1, 1'b0);
      end
      idle(2);
    end
    put(8'h03);                       // after the frame: ignored
    idle(3);
    chk_status("frame after", 1'b0, 1'b1, 1'b0);

    // back-to-back burst, upper bits masked
    put(8'hAA);
    put(8'h55);
    chk_status("burst hdr", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) put_px(8'hFF, i, 8'h07);
    chk("burst busy", 32'(bus.busy), 32'd1);
    idle(TO);                         // close the partial frame by timeout
    chk_status("burst abort", 1'b0, 1'b0, 1'b1);

    // header robustness: 12 AA AA 55 05
    put(8'h12);
    chk("hdr busy after 12", 32'(bus.busy), 32'd0);
    put(8'hAA);
    chk("hdr busy after AA", 32'(bus.busy), 32'd1);
    put(8'hAA);
    chk("hdr busy after AA AA", 32'(bus.busy), 32'd1);
    put(8'h55);
    chk_status("hdr after 55", 1'b1, 1'b0, 1'b0);
    put_px(8'h05, 0, 8'h05);

    // timeout: five pixels total, then silence
    put_px(8'h01, 1, 8'h01);
    put_px(8'h02, 2, 8'h02);
    put_px(8'hF3, 3, 8'h03);
    put_px(8'h04, 4, 8'h04);
    idle(TO - 2);
    chk_status("to before", 1'b1, 1'b0, 1'b0);
    idle(1);
    chk_status("to fired", 1'b0, 1'b0, 1'b1);
    idle(5);

    // AA then a non-header byte drops back to IDLE; error stays
    put(8'hAA);
    chk("sync busy", 32'(bus.busy), 32'd1);
    put(8'h13);
    chk_status("sync abort", 1'b0, 1'b0, 1'b1);

    // new header clears error, first write at addr 0, then reset mid-load
    put(8'hAA);
    put(8'h55);
    chk("to cleared error", 32'(bus.error), 32'd0);
    for (int i = 0; i < 20; i++) put_px(8'(i + 2), i, 8'((i + 2) % 8));
    reset_n = 1'b0;
    idle(1);
    chk("mid rst bram_we",    32'(bus.bram_we),    32'd0);
    chk("mid rst bram_addr",  32'(bus.bram_addr),  32'd0);
    chk("mid rst bram_wdata", 32'(bus.bram_wdata), 32'd0);
    chk_status("mid rst", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    put(8'hAA);
    put(8'h55);
    put_px(8'h06, 0, 8'h06);

    // byte lands on the expiry cycle: it is written, no timeout
    idle(TO - 2);
    put_px(8'h01, 1, 8'h01);
    chk_status("collide", 1'b1, 1'b0, 1'b0);
    idle(TO - 2);
    chk("collide later error", 32'(bus.error), 32'd0);
    idle(1);
    chk_status("collide to", 1'b0, 1'b0, 1'b1);

    idle(4);
    chk("pending writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
